// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, issues requests to a variable-latency instruction memory and
// feeds the F/D latch, with a one-entry hold buffer for stalls, redirect flushing and HALT.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]  HALT_OP   = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    output logic [15:0] PC_f,
    output logic [15:0] instruction_f,
    output logic        nop,
    output logic        halted
);

    typedef enum logic [1:0] {FETCH, DROP, HOLD, HALT} state_t;

    state_t      state, state_next;
    logic [15:0] pc, pc_next, pc_inc;
    logic [15:0] buf_instr, buf_instr_next;
    logic [15:0] buf_pc, buf_pc_next;
    logic [15:0] pc_f_next, instr_next;
    logic        nop_next, halted_next;

    function automatic logic is_halt(input logic [4:0] opcode);
        return opcode == HALT_OP;
    endfunction

    assign pc_inc    = pc + 16'd2;
    assign imem_req  = (state == FETCH) || (state == DROP);
    assign imem_addr = pc;

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        buf_instr_next = buf_instr;
        buf_pc_next    = buf_pc;
        pc_f_next      = PC_f;
        instr_next     = instruction_f;
        nop_next       = nop;
        halted_next    = halted;

        if (redirect) begin
            // Flush wins over stall and any response; an unanswered request must be drained.
            pc_next     = redirect_pc & 16'hFFFE;
            instr_next  = NOP_INSTR;
            nop_next    = 1'b1;
            halted_next = 1'b0;
            state_next  = (imem_req && !imem_done) ? DROP : FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_done) begin
                        pc_next = pc_inc;
                        if (stall) begin
                            buf_instr_next = imem_rdata;
                            buf_pc_next    = pc_inc;
                            state_next     = HOLD;
                        end else begin
                            instr_next = imem_rdata;
                            pc_f_next  = pc_inc;
                            nop_next   = 1'b0;
                            if (is_halt(imem_rdata[15:11])) begin
                                halted_next = 1'b1;
                                state_next  = HALT;
                            end
                        end
                    end else if (!stall) begin
                        instr_next = NOP_INSTR;
                        nop_next   = 1'b1;
                    end
                end
                DROP: begin
                    if (imem_done) begin
                        state_next = FETCH;
                    end
                    if (!stall) begin
                        instr_next = NOP_INSTR;
                        nop_next   = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instr_next = buf_instr;
                        pc_f_next  = buf_pc;
                        nop_next   = 1'b0;
                        if (is_halt(buf_instr[15:11])) begin
                            halted_next = 1'b1;
                            state_next  = HALT;
                        end else begin
                            state_next = FETCH;
                        end
                    end
                end
                HALT: begin
                    if (!stall) begin
                        instr_next = NOP_INSTR;
                        nop_next   = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            PC_f          <= 16'h0000;
            instruction_f <= NOP_INSTR;
            nop           <= 1'b1;
            halted        <= 1'b0;
        end else begin
            state         <= state_next;
            pc            <= pc_next;
            PC_f          <= pc_f_next;
            instruction_f <= instr_next;
            nop           <= nop_next;
            halted        <= halted_next;
        end
    end

    // Hold buffer contents are qualified by state, so they need no reset.
    always_ff @(posedge clk) begin
        buf_instr <= buf_instr_next;
        buf_pc    <= buf_pc_next;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then randomized
// stall/redirect/memory-latency traffic checked every cycle against a behavioural model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect, imem_done;
    logic [15:0] redirect_pc, imem_rdata;
    logic        imem_req, nop, halted;
    logic [15:0] imem_addr, PC_f, instruction_f;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model: what fetch has committed to after each edge
    logic [15:0] m_pc, m_pcf, m_ins, m_buf, m_bufpc;
    logic        m_busy, m_discard, m_bufv, m_halt, m_nop;

    // memory environment
    bit pend;
    int lat;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_done(imem_done),
        .PC_f(PC_f), .instruction_f(instruction_f), .nop(nop), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_pcf = 16'h0000; m_ins = 16'h0800; m_nop = 1'b1;
        m_busy = 1'b1; m_discard = 1'b0; m_bufv = 1'b0; m_halt = 1'b0;
    endtask

    task automatic deliver(input logic [15:0] ins, input logic [15:0] pcf);
        m_ins = ins; m_pcf = pcf; m_nop = 1'b0;
        if (ins[15:11] == 5'd0) begin
            m_halt = 1'b1; m_busy = 1'b0;
        end else begin
            m_busy = 1'b1;
        end
    endtask

    task automatic bubble();
        m_ins = 16'h0800; m_nop = 1'b1;
    endtask

    task automatic model_step(input logic st, input logic rd, input logic [15:0] rpc,
                              input logic dn, input logic [15:0] rdat);
        if (rd) begin
            m_discard = m_busy && !dn;
            m_busy = 1'b1; m_bufv = 1'b0; m_halt = 1'b0;
            m_pc = {rpc[15:1], 1'b0};
            bubble();
        end else if (m_halt) begin
            if (!st) bubble();
        end else if (m_bufv) begin
            if (!st) begin
                m_bufv = 1'b0;
                deliver(m_buf, m_bufpc);
            end
        end else if (m_discard) begin
            if (dn) m_discard = 1'b0;
            if (!st) bubble();
        end else if (dn) begin
            m_pc = m_pc + 16'd2;
            if (st) begin
                m_bufv = 1'b1; m_buf = rdat; m_bufpc = m_pc; m_busy = 1'b0;
            end else begin
                deliver(rdat, m_pc);
            end
        end else if (!st) begin
            bubble();
        end
    endtask

    task automatic check_model();
        chk("imem_req", imem_req, m_busy);
        if (m_busy) chk("imem_addr", imem_addr, m_pc);
        chk("PC_f", PC_f, m_pcf);
        chk("instruction_f", instruction_f, m_ins);
        chk("nop", nop, m_nop);
        chk("halted", halted, m_halt);
    endtask

    task automatic step(input logic st, input logic rd, input logic [15:0] rpc,
                        input logic dn, input logic [15:0] rdat);
        stall = st; redirect = rd; redirect_pc = rpc; imem_done = dn; imem_rdata = rdat;
        model_step(st, rd, rpc, dn, rdat);
        @(negedge clk);
        check_model();
    endtask

    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        pend = 1'b0;
        check_model();
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_nop", nop, 1'b1);
        @(negedge clk);
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; imem_done = 1'b0;
        check_model();
    endtask

    initial begin
        logic        dn, st, rd;
        logic [4:0]  op;
        logic [15:0] rdat;

        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        imem_done = 1'b0; imem_rdata = 16'h0;
        pend = 1'b0; lat = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_model();
        chk("reset_pcf", PC_f, 16'h0000);
        chk("reset_instr", instruction_f, 16'h0800);
        chk("reset_halted", halted, 1'b0);
        rst = 1'b0;

        // single-cycle memory, no stall
        step(0, 0, 0, 1, 16'h8801); chk("seq_pcf1", PC_f, 16'h0002); chk("seq_nop1", nop, 1'b0);
        step(0, 0, 0, 1, 16'h8802); chk("seq_pcf2", PC_f, 16'h0004);
        step(0, 0, 0, 1, 16'h8803); chk("seq_pcf3", PC_f, 16'h0006); chk("seq_ins3", instruction_f, 16'h8803);

        // three cycles of memory latency
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 16'h0);
            chk("wait_nop", nop, 1'b1);
            chk("wait_addr", imem_addr, 16'h0006);
        end
        step(0, 0, 0, 1, 16'h9000); chk("late_pcf", PC_f, 16'h0008);

        // response arrives under stall
        step(1, 0, 0, 1, 16'hA123);
        chk("stall_req", imem_req, 1'b0); chk("stall_ins", instruction_f, 16'h9000);
        step(1, 0, 0, 0, 16'h0);
        chk("stall_pcf", PC_f, 16'h0008);
        step(0, 0, 0, 0, 16'h0);
        chk("release_ins", instruction_f, 16'hA123); chk("release_pcf", PC_f, 16'h000A);

        // redirect with request outstanding
        step(0, 1, 16'h0041, 0, 16'h0);
        chk("redir_nop", nop, 1'b1); chk("redir_addr", imem_addr, 16'h0040);
        step(0, 0, 0, 1, 16'hBEEF);
        chk("drop_nop", nop, 1'b1); chk("drop_addr", imem_addr, 16'h0040);
        step(0, 0, 0, 1, 16'hC000);
        chk("after_drop_pcf", PC_f, 16'h0042); chk("after_drop_ins", instruction_f, 16'hC000);

        // halt and wrong-path recovery
        step(0, 0, 0, 1, 16'h0000);
        chk("halt_flag", halted, 1'b1); chk("halt_nop", nop, 1'b0);
        step(0, 0, 0, 0, 16'h0);
        chk("halt_req", imem_req, 1'b0); chk("halt_bubble", nop, 1'b1);
        step(0, 0, 0, 0, 16'h0);
        chk("halt_stays", halted, 1'b1);
        step(0, 1, 16'h0010, 0, 16'h0);
        chk("resume_halted", halted, 1'b0); chk("resume_addr", imem_addr, 16'h0010);

        // PC wrap
        step(0, 1, 16'hFFFF, 1, 16'h5555);
        chk("wrap_addr0", imem_addr, 16'hFFFE);
        step(0, 0, 0, 1, 16'h1234);
        chk("wrap_pcf", PC_f, 16'h0000); chk("wrap_addr", imem_addr, 16'h0000);

        // reset while a request is pending
        step(0, 0, 0, 0, 16'h0);
        mid_reset();

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                mid_reset();
            end else begin
                dn = 1'b0;
                if (imem_req) begin
                    if (!pend) begin
                        pend = 1'b1;
                        lat = $urandom_range(0, 3);
                    end
                    if (lat == 0) begin
                        dn = 1'b1;
                        pend = 1'b0;
                    end else begin
                        lat--;
                    end
                end
                op   = ($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                rdat = {op, 11'($urandom)};
                st   = ($urandom_range(0, 3) == 0);
                rd   = ($urandom_range(0, 11) == 0);
                step(st, rd, 16'($urandom), dn, rdat);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
